risc_spm: RTL and testbench
===========================

RISC_SPM -- requirements
Module: risc_spm

Interface
REQ-001 clk  input  1  single system clock; all state updates on the rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 No other ports; all state is internal and reachable by hierarchical reference:
- memory instance Ram, holding array memory[0:255] of 8-bit words;
- registers R0..R3, PC, IR, Add_R (8-bit each);
- zero flag Z and controller state.

Function
REQ-004 Ram SHALL be 256 x 8 with a combinational read and a write on the rising clk edge when the write strobe is asserted; Ram SHALL never be cleared by rst.
REQ-005 Instruction byte format:
- IR[7:4] = opcode;
- IR[3:2] = Ra (destination and first operand);
- IR[1:0] = Rb (second operand).
REQ-006 Opcodes:
- 0000 NOP;
- 0001 ADD: Ra = Ra + Rb, modulo 256;
- 0010 SUB: Ra = Ra - Rb, modulo 256, two's complement wrap;
- 0011 AND: Ra = Ra & Rb;
- 0100 NOT: Ra = ~Rb;
- 0101 RD: Ra = memory[addr];
- 0110 WR: memory[addr] = Ra;
- 0111 BR: PC = memory[addr];
- 1000 BRZ: PC = memory[addr] if Z = 1;
- 1111 HALT;
- 1001-1110 illegal, behave as HALT.
REQ-007 Two-byte instructions (RD, WR, BR, BRZ): addr is the byte at PC+1. BR and BRZ SHALL be indirect, loading PC from memory[addr].
REQ-008 Z SHALL update only on ADD, SUB, AND and NOT: Z = 1 iff the 8-bit result is 0. All other instructions leave Z unchanged.
REQ-009 Controller states: IDLE, FET1, FET2, DEC, EX1, RD1, RD2, WR1, WR2, BR1, BR2, HALT.
REQ-010 IDLE lasts one cycle after reset release, then goes to FET1.
REQ-011 Fetch and decode:
- FET1: Add_R = PC.
- FET2: IR = memory[Add_R], PC = PC + 1.
- DEC: NOP returns to FET1. ALU opcodes go to EX1. HALT and illegal opcodes go to HALT. Two-byte opcodes load Add_R = PC and set PC = PC + 1.
REQ-012 Instruction latencies:
- NOP = 3 cycles.
- ADD/SUB/AND/NOT = 4 cycles; EX1 writes Ra and Z.
- RD/WR/BR = 5 cycles. Cycle 4 loads Add_R = memory[Add_R]. Cycle 5 does the register load, the memory write, or PC = memory[Add_R].
- BRZ taken = 5 cycles.
- BRZ not taken = 3 cycles, returning to FET1 after DEC with PC already past the operand byte.
REQ-013 PC SHALL wrap from 255 to 0.
REQ-014 HALT SHALL be absorbing: no register, PC, Z or memory change until rst.
REQ-015 Ra = Rb SHALL be legal; the operation uses the register's old value.

Reset
REQ-016 While rst = 1 at a clock edge, the following SHALL be cleared to 0: PC, IR, Add_R, R0..R3 and Z. The controller SHALL enter IDLE.
REQ-017 rst asserted in any state, including HALT and mid-instruction, SHALL abort the instruction; no partial register or memory write occurs on that edge.
REQ-018 Execution SHALL restart from address 0 on the first edge after rst deasserts.

Verification
REQ-019 Countdown program:
- Stimulus: memory[0..10] = 00,54,80,50,81,24,80,82,73,83,F0 (hex); memory[128..131] = 6,1,10,5; release rst.
- Required response: HALT is reached within 100 cycles, with R1 = 0, R0 = 1, Z = 1 and PC = 11.
REQ-020 ALU program:
- Stimulus: R0 = 0xF0 and R1 = 0x0F loaded via RD; execute ADD R0,R1, then AND R0,R1, then NOT R2,R0.
- Required response: R0 = 0xFF after ADD; R0 = 0x0F with Z = 0 after AND; R2 = 0xF0 after NOT.
REQ-021 Wrap:
- Stimulus: SUB with Ra = 0 and Rb = 1.
- Required response: Ra = 0xFF and Z = 0.
REQ-022 WR then RD:
- Stimulus: WR R1 to memory[200], then RD R3 from memory[200].
- Required response: memory[200] = R1 and R3 = R1.
REQ-023 BRZ with Z = 0:
- Stimulus: BRZ executed while Z = 0.
- Required response: no branch; PC = BRZ address + 2 after exactly 3 cycles.
REQ-024 Mid-instruction reset:
- Stimulus: assert rst during RD2.
- Required response: target register unchanged from its reset value 0; PC = 0 and state IDLE after the edge.

Source files
------------

// File: rtl/risc_spm.sv
// risc_spm: 8-bit stored-program machine with a 256x8 Ram and 4 GPRs.
// Ports: clk (rising edge), rst (sync, active-high). All state is internal.
module risc_spm (
  input logic clk,
  input logic rst
);

  typedef enum logic [3:0] {
    IDLE, FET1, FET2, DEC, EX1,
    RD1, RD2, WR1, WR2, BR1, BR2, HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_RD  = 4'h5;
  localparam logic [3:0] OP_WR  = 4'h6;
  localparam logic [3:0] OP_BR  = 4'h7;
  localparam logic [3:0] OP_BRZ = 4'h8;

  state_t state, nxt;

  logic [7:0] R0, R1, R2, R3;
  logic [7:0] PC, IR, Add_R;
  logic       Z;

  logic [3:0] op;
  logic [1:0] ra_sel, rb_sel;
  logic [7:0] ra, rb, alu, wdata;
  logic [7:0] mem_rd;
  logic       mem_we;

  logic is_nop, is_alu, is_mem, is_brz;
  logic ld_ar_pc, ld_ar_mem, ld_ir, inc_pc;
  logic ld_pc, ld_ra, ld_z, wsel_mem, we_c;

  assign op     = IR[7:4];
  assign ra_sel = IR[3:2];
  assign rb_sel = IR[1:0];

  assign is_nop = (op == OP_NOP);
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) ||
                  (op == OP_AND) || (op == OP_NOT);
  assign is_mem = (op == OP_RD) || (op == OP_WR) ||
                  (op == OP_BR);
  assign is_brz = (op == OP_BRZ);

  // Memory is always addressed by Add_R; rst masks the write so an
  // aborted WR2 leaves memory untouched.
  assign mem_we = we_c & ~rst;

  if (1) begin : Ram
    logic [7:0] memory [0:255];
    always_ff @(posedge clk)
      if (mem_we) memory[Add_R] <= ra;
    assign mem_rd = memory[Add_R];
  end

  always_comb begin
    ra = R0;
    unique case (ra_sel)
      2'd0: ra = R0;
      2'd1: ra = R1;
      2'd2: ra = R2;
      2'd3: ra = R3;
    endcase
  end

  always_comb begin
    rb = R0;
    unique case (rb_sel)
      2'd0: rb = R0;
      2'd1: rb = R1;
      2'd2: rb = R2;
      2'd3: rb = R3;
    endcase
  end

  always_comb begin
    alu = 8'h00;
    case (op)
      OP_ADD:  alu = ra + rb;
      OP_SUB:  alu = ra - rb;
      OP_AND:  alu = ra & rb;
      OP_NOT:  alu = ~rb;
      default: alu = 8'h00;
    endcase
  end

  assign wdata = wsel_mem ? mem_rd : alu;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    ld_ar_pc  = 1'b0;
    ld_ar_mem = 1'b0;
    ld_ir     = 1'b0;
    inc_pc    = 1'b0;
    ld_pc     = 1'b0;
    ld_ra     = 1'b0;
    ld_z      = 1'b0;
    wsel_mem  = 1'b0;
    we_c      = 1'b0;
    unique case (state)
      IDLE: nxt = FET1;
      FET1: begin
        ld_ar_pc = 1'b1;
        nxt      = FET2;
      end
      FET2: begin
        ld_ir  = 1'b1;
        inc_pc = 1'b1;
        nxt    = DEC;
      end
      DEC: begin
        unique case (1'b1)
          is_nop: nxt = FET1;
          is_alu: nxt = EX1;
          is_mem, (is_brz & Z): begin
            ld_ar_pc = 1'b1;
            inc_pc   = 1'b1;
            nxt = (op == OP_RD) ? RD1 :
                  (op == OP_WR) ? WR1 : BR1;
          end
          // Untaken BRZ still skips its operand byte.
          (is_brz & ~Z): begin
            inc_pc = 1'b1;
            nxt    = FET1;
          end
          default: nxt = HALT;
        endcase
      end
      EX1: begin
        ld_ra = 1'b1;
        ld_z  = 1'b1;
        nxt   = FET1;
      end
      RD1: begin
        ld_ar_mem = 1'b1;
        nxt       = RD2;
      end
      RD2: begin
        ld_ra    = 1'b1;
        wsel_mem = 1'b1;
        nxt      = FET1;
      end
      WR1: begin
        ld_ar_mem = 1'b1;
        nxt       = WR2;
      end
      WR2: begin
        we_c = 1'b1;
        nxt  = FET1;
      end
      BR1: begin
        ld_ar_mem = 1'b1;
        nxt       = BR2;
      end
      BR2: begin
        ld_pc = 1'b1;
        nxt   = FET1;
      end
      HALT: nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC    <= 8'h00;
      IR    <= 8'h00;
      Add_R <= 8'h00;
      R0    <= 8'h00;
      R1    <= 8'h00;
      R2    <= 8'h00;
      R3    <= 8'h00;
      Z     <= 1'b0;
    end else begin
      if (ld_ar_pc)  Add_R <= PC;
      if (ld_ar_mem) Add_R <= mem_rd;
      if (ld_ir)     IR    <= mem_rd;
      if (inc_pc)    PC    <= PC + 8'd1;
      if (ld_pc)     PC    <= mem_rd;
      if (ld_z)      Z     <= (alu == 8'h00);
      if (ld_ra) begin
        unique case (ra_sel)
          2'd0: R0 <= wdata;
          2'd1: R1 <= wdata;
          2'd2: R2 <= wdata;
          2'd3: R3 <= wdata;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_risc_spm.sv
// tb_risc_spm: program-level checks of risc_spm using an expectation
// queue filled when a program is loaded and drained when results appear.
module tb_risc_spm;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  risc_spm dut (
    .clk(clk),
    .rst(rst)
  );

  localparam int ST_IDLE = 0;
  localparam int ST_FET1 = 1;
  localparam int ST_EX1  = 4;
  localparam int ST_RD2  = 6;
  localparam int ST_HALT = 11;

  localparam int S_R0 = 0, S_R1 = 1, S_R2 = 2, S_R3 = 3;
  localparam int S_PC = 4, S_Z = 5, S_IR = 6, S_AR = 7;
  localparam int S_ST = 8, S_M200 = 9, S_M80 = 10;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } item_t;

  item_t sb[$];
  int ncomp = 0;
  int nfail = 0;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_R0:   return dut.R0;
      S_R1:   return dut.R1;
      S_R2:   return dut.R2;
      S_R3:   return dut.R3;
      S_PC:   return dut.PC;
      S_Z:    return {7'b0, dut.Z};
      S_IR:   return dut.IR;
      S_AR:   return dut.Add_R;
      S_ST:   return 8'(dut.state);
      S_M200: return dut.Ram.memory[200];
      S_M80:  return dut.Ram.memory[8'h80];
      default: return 8'hxx;
    endcase
  endfunction

  function automatic void exp_push(input string n, input int s,
                                   input logic [7:0] v);
    item_t it;
    it.name = n;
    it.sel  = s;
    it.exp  = v;
    sb.push_back(it);
  endfunction

  // Hold reset, clear memory and make room for a new program.
  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 256; i++) dut.Ram.memory[i] = 8'h00;
  endtask

  task automatic load(input int base, input logic [7:0] b[]);
    for (int i = 0; i < b.size(); i++)
      dut.Ram.memory[(base + i) % 256] = b[i];
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_state(input int st, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (int'(dut.state) == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    item_t it;
    logic [7:0] got;
    hold_reset();
    load(0, '{8'h00, 8'h00});
    exp_push("rst_pc", S_PC, 8'h00);
    exp_push("rst_ir", S_IR, 8'h00);
    exp_push("rst_addr", S_AR, 8'h00);
    exp_push("rst_r0", S_R0, 8'h00);
    exp_push("rst_r3", S_R3, 8'h00);
    exp_push("rst_z", S_Z, 8'h00);
    exp_push("rst_state", S_ST, 8'(ST_IDLE));
    while (sb.size() > 0) begin
      it = sb.pop_front();
      got = obs(it.sel);
      ncomp++;
      if (got !== it.exp) begin
        nfail++;
        $display("FAIL %s: got %h want %h", it.name, got, it.exp);
      end
    end
    release_rst();
    exp_push("idle_to_fet1", S_ST, 8'(ST_FET1));
    @(posedge clk);
    #1;
    it = sb.pop_front();
    got = obs(it.sel);
    ncomp++;
    if (got !== it.exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", it.name, got, it.exp);
    end
  endtask

  task automatic test_countdown();
    item_t it;
    logic [7:0] got;
    bit ok;
    hold_reset();
    load(0, '{8'h00, 8'h54, 8'h80, 8'h50, 8'h81, 8'h24,
              8'h80, 8'h82, 8'h73, 8'h83, 8'hF0});
    load(128, '{8'd6, 8'd1, 8'd10, 8'd5});
    exp_push("cd_r1", S_R1, 8'h00);
    exp_push("cd_r0", S_R0, 8'h01);
    exp_push("cd_z", S_Z, 8'h01);
    exp_push("cd_pc", S_PC, 8'd11);
    release_rst();
    wait_state(ST_HALT, 100, ok);
    ncomp++;
    if (!ok) begin
      nfail++;
      $display("FAIL cd_halt: got no HALT want HALT within 100");
    end
    while (sb.size() > 0) begin
      it = sb.pop_front();
      got = obs(it.sel);
      ncomp++;
      if (got !== it.exp) begin
        nfail++;
        $display("FAIL %s: got %h want %h", it.name, got, it.exp);
      end
    end
    exp_push("cd_hold_pc", S_PC, 8'd11);
    exp_push("cd_hold_st", S_ST, 8'(ST_HALT));
    repeat (10) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      got = obs(it.sel);
      ncomp++;
      if (got !== it.exp) begin
        nfail++;
        $display("FAIL %s: got %h want %h", it.name, got, it.exp);
      end
    end
  endtask

  task automatic test_alu();
    item_t it;
    logic [7:0] got;
    bit ok;
    int npop[3] = '{1, 2, 1};
    hold_reset();
    load(0, '{8'h50, 8'h80, 8'h54, 8'h81,
              8'h11, 8'h31, 8'h48, 8'hF0});
    load(128, '{8'hF0, 8'h0F});
    exp_push("add_r0", S_R0, 8'hFF);
    exp_push("and_r0", S_R0, 8'h0F);
    exp_push("and_z", S_Z, 8'h00);
    exp_push("not_r2", S_R2, 8'hF0);
    release_rst();
    for (int k = 0; k < 3; k++) begin
      wait_state(ST_EX1, 40, ok);
      ncomp++;
      if (!ok) begin
        nfail++;
        $display("FAIL alu_ex1_%0d: got timeout want EX1", k);
      end
      @(posedge clk);
      #1;
      for (int j = 0; j < npop[k]; j++) begin
        it = sb.pop_front();
        got = obs(it.sel);
        ncomp++;
        if (got !== it.exp) begin
          nfail++;
          $display("FAIL %s: got %h want %h", it.name, got, it.exp);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_sub_wrap();
    item_t it;
    logic [7:0] got;
    bit ok;
    hold_reset();
    load(0, '{8'h55, 8'h80, 8'h21, 8'hF0});
    load(128, '{8'h01});
    exp_push("wrap_r0", S_R0, 8'hFF);
    exp_push("wrap_z", S_Z, 8'h00);
    exp_push("wrap_r1", S_R1, 8'h01);
    release_rst();
    wait_state(ST_HALT, 60, ok);
    ncomp++;
    if (!ok) begin
      nfail++;
      $display("FAIL wrap_halt: got timeout want HALT");
    end
    while (sb.size() > 0) begin
      it = sb.pop_front();
      got = obs(it.sel);
      ncomp++;
      if (got !== it.exp) begin
        nfail++;
        $display("FAIL %s: got %h want %h", it.name, got, it.exp);
      end
    end
  endtask

  task automatic test_wr_rd();
    item_t it;
    logic [7:0] got;
    bit ok;
    hold_reset();
    load(0, '{8'h54, 8'h80, 8'h64, 8'hC8,
              8'h5C, 8'hC8, 8'hF0});
    load(128, '{8'h5A});
    exp_push("wr_mem200", S_M200, 8'h5A);
    exp_push("rd_r3", S_R3, 8'h5A);
    release_rst();
    wait_state(ST_HALT, 60, ok);
    ncomp++;
    if (!ok) begin
      nfail++;
      $display("FAIL wrrd_halt: got timeout want HALT");
    end
    while (sb.size() > 0) begin
      it = sb.pop_front();
      got = obs(it.sel);
      ncomp++;
      if (got !== it.exp) begin
        nfail++;
        $display("FAIL %s: got %h want %h", it.name, got, it.exp);
      end
    end
  endtask

  task automatic test_brz_not_taken();
    item_t it;
    logic [7:0] got;
    hold_reset();
    load(0, '{8'h80, 8'h40, 8'hF0});
    load(8'h40, '{8'h30});
    release_rst();
    @(posedge clk);
    #1;
    exp_push("brznt_state", S_ST, 8'(ST_FET1));
    exp_push("brznt_pc", S_PC, 8'h02);
    exp_push("brznt_ir", S_IR, 8'h80);
    repeat (3) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      got = obs(it.sel);
      ncomp++;
      if (got !== it.exp) begin
        nfail++;
        $display("FAIL %s: got %h want %h", it.name, got, it.exp);
      end
    end
  endtask

  task automatic test_brz_taken();
    item_t it;
    logic [7:0] got;
    bit ok;
    hold_reset();
    load(0, '{8'h58, 8'h80, 8'h1A, 8'h80, 8'h40});
    load(8'h40, '{8'h30});
    load(8'h30, '{8'hF0});
    load(128, '{8'h80});
    exp_push("brzt_r2", S_R2, 8'h00);
    exp_push("brzt_z", S_Z, 8'h01);
    exp_push("brzt_pc", S_PC, 8'h31);
    release_rst();
    wait_state(ST_HALT, 60, ok);
    ncomp++;
    if (!ok) begin
      nfail++;
      $display("FAIL brzt_halt: got timeout want HALT");
    end
    while (sb.size() > 0) begin
      it = sb.pop_front();
      got = obs(it.sel);
      ncomp++;
      if (got !== it.exp) begin
        nfail++;
        $display("FAIL %s: got %h want %h", it.name, got, it.exp);
      end
    end
  endtask

  task automatic test_pc_wrap_illegal();
    item_t it;
    logic [7:0] got;
    bit ok;
    hold_reset();
    load(0, '{8'h70, 8'h40});
    load(8'h40, '{8'hFE});
    load(8'hFE, '{8'h00, 8'h9C});
    exp_push("wrap_pc", S_PC, 8'h00);
    exp_push("illegal_ir", S_IR, 8'h9C);
    exp_push("illegal_st", S_ST, 8'(ST_HALT));
    exp_push("illegal_r3", S_R3, 8'h00);
    release_rst();
    wait_state(ST_HALT, 60, ok);
    ncomp++;
    if (!ok) begin
      nfail++;
      $display("FAIL illegal_halt: got timeout want HALT");
    end
    repeat (20) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      got = obs(it.sel);
      ncomp++;
      if (got !== it.exp) begin
        nfail++;
        $display("FAIL %s: got %h want %h", it.name, got, it.exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    item_t it;
    logic [7:0] got;
    bit ok;
    hold_reset();
    load(0, '{8'h5C, 8'h80, 8'hF0});
    load(128, '{8'h77});
    exp_push("mid_r3", S_R3, 8'h00);
    exp_push("mid_pc", S_PC, 8'h00);
    exp_push("mid_st", S_ST, 8'(ST_IDLE));
    exp_push("mid_ir", S_IR, 8'h00);
    exp_push("mid_ram_kept", S_M80, 8'h77);
    release_rst();
    wait_state(ST_RD2, 30, ok);
    ncomp++;
    if (!ok) begin
      nfail++;
      $display("FAIL mid_rd2: got timeout want RD2");
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      got = obs(it.sel);
      ncomp++;
      if (got !== it.exp) begin
        nfail++;
        $display("FAIL %s: got %h want %h", it.name, got, it.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_alu();
    test_sub_wrap();
    test_wr_rd();
    test_brz_not_taken();
    test_brz_taken();
    test_pc_wrap_illegal();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncomp, nfail);
    $finish;
  end

endmodule
